decode_issue_controller: RTL and testbench
==========================================

Name: decode_issue_controller

Overview:
- Sits between instruction fetch and the bank of format decoders (MD/MDS, D, X, XO, ...), which share one broadcast instruction bus.
- Buffers fetched instructions in a small FIFO and issues one per cycle to all decoders via a shared enable/instruction/address bus.
- Issue is gated by downstream credits, because the decoders have no stall input.
- Detects instructions that no decoder claims and reports them as illegal.

Parameters:
instructionWidth, 32, instruction word width (big-endian bit order [0:N-1])
addressSize, 64, instruction address width
fifoDepth, 4, instruction buffer entries; power of 2, at least 2
creditCount, 4, downstream decoded-instruction slots; at least 1
creditWidth, 3, width of credit counter; must hold creditCount

Ports:
clock_i  in  1  clock; all logic on posedge
reset_i  in  1  synchronous, active-high reset
fetch_valid_i  in  1  fetch offers an instruction
fetch_instruction_i  in  [0:instructionWidth-1]  fetched instruction
fetch_address_i  in  [0:addressSize-1]  address of fetched instruction
fetch_ready_o  out  1  buffer can accept; push = fetch_valid_i & fetch_ready_o
flush_i  in  1  discard all buffered and in-flight work
dec_enable_o  out  1  drives enable_i of every format decoder
dec_instruction_o  out  [0:instructionWidth-1]  drives instruction_i of every decoder
dec_address_o  out  [0:addressSize-1]  drives address_i of every decoder
dec_hit_i  in  1  OR of all decoder enable_o outputs
credit_return_i  in  1  downstream freed one slot this cycle
illegal_o  out  1  one-cycle pulse: issued instruction claimed by no decoder
illegal_instruction_o  out  [0:instructionWidth-1]  the unclaimed instruction, valid with illegal_o
illegal_address_o  out  [0:addressSize-1]  its address, valid with illegal_o

Behaviour:
- Reset (reset_i=1 at posedge): FIFO empty, credits=creditCount, checkPending=0.
- Reset outputs: dec_enable_o=0, dec_instruction_o=0, dec_address_o=0, illegal_o=0, illegal_instruction_o=0, illegal_address_o=0.
- Reset overrides flush and all other inputs. fetch_ready_o=1 in the first cycle after reset.
- fetch_ready_o is combinational: (count != fifoDepth). A full FIFO refuses a push even if a pop happens in the same cycle.
- Issue condition: FIFO non-empty and credits>0 and !flush_i.
- On issue: pop the head. Next cycle dec_enable_o=1 and dec_instruction_o/dec_address_o carry the popped entry, all registered. Otherwise dec_enable_o=0 and the data outputs hold their previous value.
- Latency: an instruction pushed into an empty FIFO at edge E appears on dec_* after edge E+1, given credits are available. Zero-cycle bypass is not allowed.
- Push into an empty FIFO and issue of the same entry cannot happen in the same cycle.
- Push and pop in the same cycle (count between 1 and fifoDepth-1) leaves count unchanged. Pointers wrap modulo fifoDepth. Order is strictly FIFO.
- Credits:
  - decrement on issue, increment on credit_return_i;
  - issue together with return gives a net change of 0;
  - credit_return_i while credits==creditCount is a protocol error: credits saturate and the bench asserts.
- Claim check:
  - Decoders register their outputs, so dec_hit_i for an instruction driven in cycle T arrives in cycle T+1.
  - checkPending is set for cycle T+1 together with a copy of that instruction and address.
  - If checkPending=1 and dec_hit_i=0, then in cycle T+2: illegal_o=1, illegal_* carry the copy, and the controller returns the consumed credit to itself.
  - This self-return adds to credit_return_i in the same cycle; the combined count is still capped at creditCount.
- Back-to-back issue: checks overlap by one cycle. Each check uses its own pipeline copy, so illegal_o can pulse on consecutive cycles.
- Flush (flush_i=1 at posedge):
  - FIFO emptied; no push and no issue that cycle;
  - dec_enable_o=0 next cycle; checkPending cleared, so no illegal_o for cancelled work;
  - credits reloaded to creditCount, because downstream flushes in the same cycle;
  - credit_return_i in the flush cycle is ignored.
- Flush asserted for several cycles keeps the block idle. Normal operation resumes the cycle after flush_i falls.

Test Plan:
- Reset, then push 0x7C221A14@0x1000 with dec_hit_i=1 a cycle after issue -> dec_enable_o=1 with that word/address exactly 2 edges after push; illegal_o stays 0.
- creditCount=2, no returns, push 4 instructions -> exactly 2 issued; after the 2nd push the remaining ones wait in the FIFO; one credit_return_i -> next instruction issues on the following cycle.
- Push 6 back-to-back with credits blocked -> fetch_ready_o drops to 0 after 4 accepted; words 5-6 held until a pop; issue order preserved across pointer wrap.
- Issue 0x00000000@0x2000 with dec_hit_i=0 -> illegal_o pulses once, 2 cycles after dec_enable_o, with illegal_instruction_o=0, illegal_address_o=0x2000; credits return to the prior value.
- Flush while FIFO holds 3 and one check is pending with dec_hit_i=0 -> no illegal_o; fetch_ready_o=1; credits=creditCount; a push after flush issues normally.
- credit_return_i together with issue at credits=1 -> credits stay 1; issue continues the next cycle.

Source files
------------

// File: rtl/decode_issue_controller.sv
// Decode issue controller: buffers fetched instructions, broadcasts one per cycle
// to the format decoders under credit control, and flags words no decoder claims.
module decode_issue_controller #(
  parameter int instructionWidth = 32,
  parameter int addressSize      = 64,
  parameter int fifoDepth        = 4,
  parameter int creditCount      = 4,
  parameter int creditWidth      = 3
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        fetch_valid_i,
  input  logic [0:instructionWidth-1] fetch_instruction_i,
  input  logic [0:addressSize-1]      fetch_address_i,
  output logic                        fetch_ready_o,
  input  logic                        flush_i,
  output logic                        dec_enable_o,
  output logic [0:instructionWidth-1] dec_instruction_o,
  output logic [0:addressSize-1]      dec_address_o,
  input  logic                        dec_hit_i,
  input  logic                        credit_return_i,
  output logic                        illegal_o,
  output logic [0:instructionWidth-1] illegal_instruction_o,
  output logic [0:addressSize-1]      illegal_address_o
);

  localparam int PtrW = (fifoDepth > 1) ? $clog2(fifoDepth) : 1;
  localparam int CntW = $clog2(fifoDepth) + 1;
  localparam int SumW = creditWidth + 1;

  logic [0:instructionWidth-1] instr_mem [fifoDepth];
  logic [0:addressSize-1]      addr_mem  [fifoDepth];

  logic [PtrW-1:0]             rd_ptr, wr_ptr;
  logic [CntW-1:0]             count;
  logic [creditWidth-1:0]      credits, credits_next;
  logic [SumW-1:0]             credit_sum;
  // [0] decoder enable stage, [1] claim check pending stage
  logic [1:0]                  vld_pipe;
  logic [0:instructionWidth-1] chk_instr;
  logic [0:addressSize-1]      chk_addr;
  logic                        push, pop, miss;

  assign fetch_ready_o = (count != CntW'(fifoDepth));
  assign push          = fetch_valid_i & fetch_ready_o & ~flush_i;
  // Count is registered, so a word pushed into an empty buffer cannot pop the same cycle.
  assign pop           = (count != '0) & (credits != '0) & ~flush_i;
  assign miss          = vld_pipe[1] & ~dec_hit_i;
  assign dec_enable_o  = vld_pipe[0];

  // A reported illegal word hands its credit back alongside any external return.
  always_comb begin
    credit_sum   = SumW'(credits) + SumW'(credit_return_i) + SumW'(illegal_o) - SumW'(pop);
    credits_next = credits;
    if (credit_sum > SumW'(creditCount))
      credits_next = creditWidth'(creditCount);
    else
      credits_next = credit_sum[creditWidth-1:0];
  end

  always_ff @(posedge clock_i) begin
    if (push && !reset_i) begin
      instr_mem[wr_ptr] <= fetch_instruction_i;
      addr_mem[wr_ptr]  <= fetch_address_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rd_ptr                <= '0;
      wr_ptr                <= '0;
      count                 <= '0;
      credits               <= creditWidth'(creditCount);
      vld_pipe              <= '0;
      dec_instruction_o     <= '0;
      dec_address_o         <= '0;
      chk_instr             <= '0;
      chk_addr              <= '0;
      illegal_o             <= 1'b0;
      illegal_instruction_o <= '0;
      illegal_address_o     <= '0;
    end else if (flush_i) begin
      // Downstream flushes with us, so every slot is free again.
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      credits   <= creditWidth'(creditCount);
      vld_pipe  <= '0;
      illegal_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
      credits  <= credits_next;
      vld_pipe <= {vld_pipe[0], pop};
      if (pop) begin
        dec_instruction_o <= instr_mem[rd_ptr];
        dec_address_o     <= addr_mem[rd_ptr];
      end
      // Own copy per check so back-to-back issues can both be reported.
      if (vld_pipe[0]) begin
        chk_instr <= dec_instruction_o;
        chk_addr  <= dec_address_o;
      end
      illegal_o <= miss;
      if (miss) begin
        illegal_instruction_o <= chk_instr;
        illegal_address_o     <= chk_addr;
      end
    end
  end

endmodule

// File: tb/tb_decode_issue_controller.sv
// Directed bench for decode_issue_controller (two downstream credits).
module tb_decode_issue_controller;

  logic        clock_i = 1'b0;
  logic        reset_i, fetch_valid_i, flush_i, dec_hit_i, credit_return_i;
  logic [0:31] fetch_instruction_i, dec_instruction_o, illegal_instruction_o;
  logic [0:63] fetch_address_i, dec_address_o, illegal_address_o;
  logic        fetch_ready_o, dec_enable_o, illegal_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] w [8];

  decode_issue_controller #(
    .instructionWidth(32), .addressSize(64), .fifoDepth(4),
    .creditCount(2), .creditWidth(3)
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .fetch_valid_i(fetch_valid_i), .fetch_instruction_i(fetch_instruction_i),
    .fetch_address_i(fetch_address_i), .fetch_ready_o(fetch_ready_o),
    .flush_i(flush_i), .dec_enable_o(dec_enable_o),
    .dec_instruction_o(dec_instruction_o), .dec_address_o(dec_address_o),
    .dec_hit_i(dec_hit_i), .credit_return_i(credit_return_i),
    .illegal_o(illegal_o), .illegal_instruction_o(illegal_instruction_o),
    .illegal_address_o(illegal_address_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] adr);
    fetch_valid_i       = v;
    fetch_instruction_i = ins;
    fetch_address_i     = adr;
  endtask

  task automatic chk_issue(input string tag, input logic [31:0] ins, input logic [63:0] adr);
    chk({tag, "_en"}, dec_enable_o, 1);
    chk({tag, "_ins"}, dec_instruction_o, ins);
    chk({tag, "_adr"}, dec_address_o, adr);
  endtask

  initial begin
    w[0] = 32'h38600001; w[1] = 32'h38800002; w[2] = 32'h7C632214; w[3] = 32'h90610008;
    w[4] = 32'h80810010; w[5] = 32'h60000000; w[6] = 32'h4E800020; w[7] = 32'hE8410018;
    reset_i = 1'b1; flush_i = 1'b0; dec_hit_i = 1'b1; credit_return_i = 1'b0;
    drive(1'b0, 32'h0, 64'h0);

    // Reset state
    tick(); tick();
    chk("rst_en", dec_enable_o, 0);
    chk("rst_ins", dec_instruction_o, 0);
    chk("rst_adr", dec_address_o, 0);
    chk("rst_ill", illegal_o, 0);
    chk("rst_ill_ins", illegal_instruction_o, 0);
    chk("rst_ill_adr", illegal_address_o, 0);
    chk("rst_ready", fetch_ready_o, 1);
    reset_i = 1'b0;

    // Single issue latency, claimed word
    drive(1'b1, 32'h7C221A14, 64'h1000);
    tick(); drive(1'b0, 32'h0, 64'h0);
    chk("t1_no_bypass", dec_enable_o, 0);
    tick(); chk_issue("t1_issue", 32'h7C221A14, 64'h1000);
    tick(); chk("t1_en_drop", dec_enable_o, 0);
    tick(); chk("t1_ill", illegal_o, 0);
    tick(); chk("t1_ill2", illegal_o, 0);

    flush_i = 1'b1; tick(); flush_i = 1'b0;
    chk("fl0_en", dec_enable_o, 0);
    chk("fl0_ready", fetch_ready_o, 1);

    // Two credits, four pushes: only two issue until a credit returns
    drive(1'b1, w[0], 64'h5000); tick();
    drive(1'b1, w[1], 64'h5004); tick(); chk_issue("t2_a0", w[0], 64'h5000);
    drive(1'b1, w[2], 64'h5008); tick(); chk_issue("t2_a1", w[1], 64'h5004);
    drive(1'b1, w[3], 64'h500C); tick(); chk("t2_starve", dec_enable_o, 0);
    drive(1'b0, 32'h0, 64'h0);
    tick(); tick(); chk("t2_starve2", dec_enable_o, 0);
    credit_return_i = 1'b1; tick(); credit_return_i = 1'b0;
    chk("t2_ret_cycle", dec_enable_o, 0);
    tick(); chk_issue("t2_a2", w[2], 64'h5008);
    tick(); chk("t2_starve3", dec_enable_o, 0);

    flush_i = 1'b1; tick(); flush_i = 1'b0;

    // Fill to full with credits exhausted, then drain across pointer wrap
    drive(1'b1, w[0], 64'h4000); tick();
    drive(1'b1, w[1], 64'h4004); tick(); chk_issue("t3_w0", w[0], 64'h4000);
    drive(1'b1, w[2], 64'h4008); tick(); chk_issue("t3_w1", w[1], 64'h4004);
    drive(1'b1, w[3], 64'h400C); tick(); chk("t3_ready3", fetch_ready_o, 1);
    drive(1'b1, w[4], 64'h4010); tick(); chk("t3_ready4", fetch_ready_o, 1);
    drive(1'b1, w[5], 64'h4014); tick(); chk("t3_full", fetch_ready_o, 0);
    drive(1'b1, w[6], 64'h4018); tick(); chk("t3_full2", fetch_ready_o, 0);
    tick(); chk("t3_hold_en", dec_enable_o, 0);
    credit_return_i = 1'b1; tick(); credit_return_i = 1'b0;
    chk("t3_full_ret", fetch_ready_o, 0);
    tick(); chk_issue("t3_w2", w[2], 64'h4008);
    chk("t3_ready_pop", fetch_ready_o, 1);
    tick(); chk("t3_w6_in", fetch_ready_o, 0);
    chk("t3_en_idle", dec_enable_o, 0);
    drive(1'b0, 32'h0, 64'h0);
    credit_return_i = 1'b1;
    tick(); chk("t3_ret_only", dec_enable_o, 0);
    tick(); chk_issue("t3_w3", w[3], 64'h400C);
    tick(); chk_issue("t3_w4", w[4], 64'h4010);
    tick(); chk_issue("t3_w5", w[5], 64'h4014);
    tick(); chk_issue("t3_w6", w[6], 64'h4018);
    credit_return_i = 1'b0;
    tick(); chk("t3_empty", dec_enable_o, 0);

    flush_i = 1'b1; tick(); flush_i = 1'b0;

    // Unclaimed word
    drive(1'b1, 32'h0, 64'h2000); tick(); drive(1'b0, 32'h0, 64'h0);
    tick(); chk_issue("t4_issue", 32'h0, 64'h2000);
    tick(); chk("t4_ill_early", illegal_o, 0);
    dec_hit_i = 1'b0;
    tick(); chk("t4_ill", illegal_o, 1);
    chk("t4_ill_ins", illegal_instruction_o, 0);
    chk("t4_ill_adr", illegal_address_o, 64'h2000);
    dec_hit_i = 1'b1;
    tick(); chk("t4_ill_once", illegal_o, 0);

    // Back-to-back unclaimed words; both issuing shows the credit came back
    drive(1'b1, w[7], 64'h3000); tick();
    drive(1'b1, w[4], 64'h3004); tick(); chk_issue("t5_g0", w[7], 64'h3000);
    drive(1'b0, 32'h0, 64'h0);   tick(); chk_issue("t5_g1", w[4], 64'h3004);
    dec_hit_i = 1'b0;
    tick(); chk("t5_ill0", illegal_o, 1);
    chk("t5_ill0_ins", illegal_instruction_o, w[7]);
    chk("t5_ill0_adr", illegal_address_o, 64'h3000);
    tick(); chk("t5_ill1", illegal_o, 1);
    chk("t5_ill1_ins", illegal_instruction_o, w[4]);
    chk("t5_ill1_adr", illegal_address_o, 64'h3004);
    dec_hit_i = 1'b1;
    tick(); chk("t5_ill_end", illegal_o, 0);

    // Flush with three buffered and an unclaimed check pending
    drive(1'b1, w[0], 64'h6000); tick();
    drive(1'b1, w[1], 64'h6004); tick();
    drive(1'b1, w[2], 64'h6008); tick();
    drive(1'b1, w[3], 64'h600C); tick();
    drive(1'b1, w[4], 64'h6010); tick();
    drive(1'b1, w[5], 64'h6014); tick(); chk("t6_full", fetch_ready_o, 0);
    drive(1'b0, 32'h0, 64'h0);
    credit_return_i = 1'b1; tick(); credit_return_i = 1'b0;
    tick(); chk_issue("t6_h2", w[2], 64'h6008);
    tick(); chk("t6_en0", dec_enable_o, 0);
    dec_hit_i = 1'b0; flush_i = 1'b1;
    tick(); chk("t6_fl_ill", illegal_o, 0);
    chk("t6_fl_ready", fetch_ready_o, 1);
    chk("t6_fl_en", dec_enable_o, 0);
    flush_i = 1'b0; dec_hit_i = 1'b1;
    tick(); chk("t6_fl_ill2", illegal_o, 0);
    drive(1'b1, w[6], 64'h7000); tick();
    drive(1'b1, w[7], 64'h7004); tick(); chk_issue("t6_p0", w[6], 64'h7000);
    drive(1'b0, 32'h0, 64'h0);   tick(); chk_issue("t6_p1", w[7], 64'h7004);
    tick(); chk("t6_p_end", dec_enable_o, 0);

    // Multi-cycle flush keeps the block idle and blocks pushes
    flush_i = 1'b1; drive(1'b1, w[1], 64'h8000);
    tick(); chk("t7_fl1", dec_enable_o, 0);
    tick(); chk("t7_fl2", dec_enable_o, 0);
    tick(); chk("t7_fl3", dec_enable_o, 0);
    flush_i = 1'b0;
    tick(); drive(1'b0, 32'h0, 64'h0);
    chk("t7_push", dec_enable_o, 0);
    tick(); chk_issue("t7_q0", w[1], 64'h8000);
    tick(); chk("t7_single", dec_enable_o, 0);

    // Reset wins over flush and fetch
    reset_i = 1'b1; flush_i = 1'b1; drive(1'b1, w[2], 64'h9000);
    tick(); reset_i = 1'b0; flush_i = 1'b0; drive(1'b0, 32'h0, 64'h0);
    chk("t8_rst_ins", dec_instruction_o, 0);
    chk("t8_rst_ill_adr", illegal_address_o, 0);
    tick(); chk("t8_no_push", dec_enable_o, 0);
    tick(); chk("t8_no_push2", dec_enable_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
